// File: rtl/pingpong_mem_ctrl.sv
// Ping-pong sample buffer between a producer and a 1-cycle-latency reader.
// Two on-chip memory banks alternate between fill and drain.
//
// Ports:
//   clk_clk, reset_reset_n    : clock, async active-low reset
//   flush                     : sync clear of pointers and full flags
//   wr_valid/wr_data/wr_ready : producer sample handshake
//   rd_req/rd_valid/rd_data   : consumer request and 1-cycle response
//   underrun, underrun_cnt    : miss pulse and saturating miss count
//   bank_full                 : per-bank full flags
//   m0_*, m1_*                : on-chip memory slave ports
module pingpong_mem_ctrl #(
  parameter int DEPTH = 256
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        flush,
  input  logic        wr_valid,
  input  logic [15:0] wr_data,
  output logic        wr_ready,
  input  logic        rd_req,
  output logic        rd_valid,
  output logic [15:0] rd_data,
  output logic        underrun,
  output logic [15:0] underrun_cnt,
  output logic [1:0]  bank_full,
  output logic [7:0]  m0_address,
  output logic        m0_chipselect,
  output logic        m0_write,
  output logic [15:0] m0_writedata,
  output logic [1:0]  m0_byteenable,
  output logic        m0_clken,
  input  logic [15:0] m0_readdata,
  output logic [7:0]  m1_address,
  output logic        m1_chipselect,
  output logic        m1_write,
  output logic [15:0] m1_writedata,
  output logic [1:0]  m1_byteenable,
  output logic        m1_clken,
  input  logic [15:0] m1_readdata
);

  localparam logic [7:0] LAST = 8'(DEPTH - 1);

  logic        wr_bank;
  logic        rd_bank;
  logic [7:0]  wr_addr;
  logic [7:0]  rd_addr;
  logic [1:0]  full_q;
  logic [1:0]  full_nxt;
  logic        rd_pend;
  logic        rd_sel;
  logic        miss_q;
  logic [15:0] cnt_q;

  logic wr_xfer;
  logic rd_acc;
  logic rd_miss;
  logic wr_last;
  logic rd_last;

  // Gating with reset keeps every strobe low while reset is held,
  // without waiting for a clock edge.
  assign wr_ready = reset_reset_n & ~full_q[wr_bank] & ~flush;
  assign wr_xfer  = wr_valid & wr_ready;
  assign rd_acc   = reset_reset_n & rd_req
                  & full_q[rd_bank] & ~flush;
  assign rd_miss  = reset_reset_n & rd_req & ~rd_acc;
  assign wr_last  = wr_xfer & (wr_addr == LAST);
  assign rd_last  = rd_acc & (rd_addr == LAST);

  // Set and clear always hit different banks, so both apply.
  always_comb begin
    full_nxt = full_q;
    if (wr_last) full_nxt[wr_bank] = 1'b1;
    if (rd_last) full_nxt[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_addr <= '0;
      rd_addr <= '0;
      full_q  <= '0;
      rd_pend <= 1'b0;
      rd_sel  <= 1'b0;
      miss_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      // A read already issued still returns its data across a flush.
      rd_pend <= rd_acc;
      miss_q  <= rd_miss;
      if (rd_acc) rd_sel <= rd_bank;
      if (rd_miss && cnt_q != 16'hFFFF)
        cnt_q <= cnt_q + 16'd1;
      if (flush) begin
        wr_bank <= 1'b0;
        rd_bank <= 1'b0;
        wr_addr <= '0;
        rd_addr <= '0;
        full_q  <= '0;
      end else begin
        full_q <= full_nxt;
        if (wr_last) begin
          wr_addr <= '0;
          wr_bank <= ~wr_bank;
        end else if (wr_xfer) begin
          wr_addr <= wr_addr + 8'd1;
        end
        if (rd_last) begin
          rd_addr <= '0;
          rd_bank <= ~rd_bank;
        end else if (rd_acc) begin
          rd_addr <= rd_addr + 8'd1;
        end
      end
    end
  end

  assign rd_valid     = rd_pend | miss_q;
  assign rd_data      = rd_pend ? (rd_sel ? m1_readdata
                                          : m0_readdata)
                                : 16'h0000;
  assign underrun     = miss_q;
  assign underrun_cnt = cnt_q;
  assign bank_full    = full_q;

  assign m0_clken      = 1'b1;
  assign m1_clken      = 1'b1;
  assign m0_byteenable = 2'b11;
  assign m1_byteenable = 2'b11;

  logic wr0, wr1, rd0, rd1;
  assign wr0 = wr_xfer & ~wr_bank;
  assign wr1 = wr_xfer &  wr_bank;
  assign rd0 = rd_acc  & ~rd_bank;
  assign rd1 = rd_acc  &  rd_bank;

  always_comb begin
    m0_chipselect = wr0 | rd0;
    m0_write      = wr0;
    m0_writedata  = wr0 ? wr_data : 16'h0000;
    m0_address    = 8'h00;
    if (wr0)      m0_address = wr_addr;
    else if (rd0) m0_address = rd_addr;
  end

  always_comb begin
    m1_chipselect = wr1 | rd1;
    m1_write      = wr1;
    m1_writedata  = wr1 ? wr_data : 16'h0000;
    m1_address    = 8'h00;
    if (wr1)      m1_address = wr_addr;
    else if (rd1) m1_address = rd_addr;
  end

endmodule
